// File: rtl/dog_dt_wr.sv
// Write-back address generator for the DoG separable filter: drops window-fill
// samples per padded line and routes pass-0 results to ram1, pass-1 results to ram0.
module dog_dt_wr #(
    parameter int LINE_LEN = 262,
    parameter int DROP     = 6,
    parameter int DW       = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          ram0_wr_en,
    output logic [15:0]   ram0_wr_addr,
    output logic [DW-1:0] ram0_wr_data,
    output logic          ram1_wr_en,
    output logic [15:0]   ram1_wr_addr,
    output logic [DW-1:0] ram1_wr_data,
    output logic          busy,
    output logic          done,
    output logic          overflow,
    output logic [1:0]    fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS0 = 2'd1,
        PASS1 = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [8:0] LAST_POS = 9'(LINE_LEN - 1);
    localparam logic [8:0] DROP_POS = 9'(DROP);

    state_t     state;
    state_t     state_next;
    logic [8:0] pos;
    logic [7:0] line;
    logic       accept;
    logic       keep;
    logic       line_end;
    logic [7:0] col;

    always_comb begin
        accept     = in_valid && (state == PASS0 || state == PASS1);
        keep       = accept && (pos >= DROP_POS);
        line_end   = accept && (pos == LAST_POS);
        col        = 8'(pos - DROP_POS);
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = PASS0;
            PASS0:   if (line_end && line == 8'hFF) state_next = PASS1;
            PASS1:   if (line_end && line == 8'hFF) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Counters, sticky overflow and the registered write ports.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pos          <= '0;
            line         <= '0;
            overflow     <= 1'b0;
            ram0_wr_en   <= 1'b0;
            ram0_wr_addr <= '0;
            ram0_wr_data <= '0;
            ram1_wr_en   <= 1'b0;
            ram1_wr_addr <= '0;
            ram1_wr_data <= '0;
        end else begin
            ram0_wr_en   <= 1'b0;
            ram0_wr_addr <= '0;
            ram0_wr_data <= '0;
            ram1_wr_en   <= 1'b0;
            ram1_wr_addr <= '0;
            ram1_wr_data <= '0;

            if (state == IDLE && start) begin
                pos      <= '0;
                line     <= '0;
                overflow <= 1'b0;
            end else if (in_valid && (state == IDLE || state == DONE)) begin
                overflow <= 1'b1;
            end

            if (accept) begin
                if (line_end) begin
                    pos  <= '0;
                    line <= line + 8'd1;
                end else begin
                    pos <= pos + 9'd1;
                end
            end

            // Pass 1 swaps the fields so the transposed stream lands row-major.
            if (keep) begin
                if (state == PASS0) begin
                    ram1_wr_en   <= 1'b1;
                    ram1_wr_addr <= {line, col};
                    ram1_wr_data <= in_data;
                end else begin
                    ram0_wr_en   <= 1'b1;
                    ram0_wr_addr <= {col, line};
                    ram0_wr_data <= in_data;
                end
            end
        end
    end

    assign busy      = (state == PASS0) || (state == PASS1);
    assign done      = (state == DONE);
    assign fsm_state = state;

endmodule

// File: doc/dog_dt_wr.md
# dog_dt_wr

Write-back address generator for the DoG separable filter, paired with the read sequencer that streams mirror-padded rows (ram0, row-major) and then columns (ram1, transposed). It accepts the filter's output sample stream, drops the window-fill samples of every padded line, and writes the 256 valid results per line to the correct RAM and address. Pass 0 (horizontal) results go to ram1; pass 1 (vertical) results go back to ram0 in row-major order. It sits between the 7-tap filter datapath and the two frame RAMs' write ports.

## Interface
- LINE_LEN, 262: samples per padded line arriving from the filter (x = -3..258)
- DROP, 6: leading samples of each line discarded (7-tap window fill)
- DW, 8: data width

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse, begins a frame (ignored unless IDLE)
- in_valid  in  1  filter output sample valid; no backpressure
- in_data  in  DW  filter output sample
- ram0_wr_en  out  1  ram0 write strobe
- ram0_wr_addr  out  16  ram0 write address {row, col}
- ram0_wr_data  out  DW  ram0 write data
- ram1_wr_en  out  1  ram1 write strobe
- ram1_wr_addr  out  16  ram1 write address {row, col}
- ram1_wr_data  out  DW  ram1 write data
- busy  out  1  high in PASS0/PASS1
- done  out  1  one-cycle pulse at frame completion
- overflow  out  1  sticky: in_valid seen in IDLE/DONE

## Operation
- States: IDLE, PASS0, PASS1, DONE.
- IDLE --start--> PASS0; clears sample counter pos (9b), line counter line (8b), overflow.
- Per accepted in_valid in PASS0/PASS1: if pos < DROP, discard; else col = pos - DROP (8b, 0..255), issue write. pos increments; at pos == LINE_LEN-1 pos wraps to 0 and line increments.
- PASS0 write: ram1, addr = {line, col}, data = in_data. (Row index = line, column = col; matches transposed read of ram1 as {x, y}.)
- PASS1 write: ram0, addr = {col, line}. (line = image column, col = image row → row-major result.)
- Line 255 last sample in PASS0 → PASS1, line wraps to 0. Same event in PASS1 → DONE.
- DONE: lasts one cycle, done = 1, then IDLE.
- start while busy or in DONE: ignored (counters unaffected).
- in_valid in IDLE or DONE: no write, overflow <= 1; overflow holds until next accepted start.
- Never both write enables in one cycle; inactive port's addr/data held at 0.
- Gaps in in_valid allowed anywhere; counters advance only on in_valid.

## Timing
- Reset (rst_n low at clk edge): state IDLE, pos 0, line 0; all outputs 0.
- Reset mid-frame: aborts on the same edge, no further writes, no done.
- Write latency: 1 cycle; in_valid/in_data at edge n → wr_en/addr/data registered at edge n+1, valid for one cycle.
- busy rises the cycle after start; drops the cycle done is high.
- Frame: 2 × 256 × 262 = 134144 accepted samples; 131072 writes (65536 per RAM).
- done asserted the cycle after the transition edge of the final sample, coincident with its (last) ram0 write? No: final write at edge n+1, done at edge n+1 as well (DONE entered on same edge); both high together for one cycle.
- Address arithmetic modulo 2^8 per byte; no carry between row and column fields.

## Test plan
- Reset: hold rst_n low 3 cycles with in_valid = 1 → all outputs 0, overflow 0, no writes.
- Single line: start, then 262 consecutive in_valid with in_data = pos[7:0] → samples 0..5 dropped; ram1 writes addr 0x0000..0x00FF with data 6..261 mod 256, one cycle after each sample.
- Full frame with random 30% in_valid gaps: exactly 65536 ram1 writes (addr {line,col}) then 65536 ram0 writes; last ram0 write addr 0xFFFF with done = 1 same cycle; busy low next cycle.
- PASS1 addressing: second pass, line 3, pos 10 → ram0_wr_addr = 0x0403 (col 4, line 3).
- Illegal events: start pulsed mid PASS0 → counters unchanged; in_valid in IDLE → overflow = 1 until next start, no write.
- Reset at PASS1 line 100 → next edge outputs 0, state IDLE; fresh start runs a complete frame correctly.
